hs32_aicx: RTL and testbench
============================

# hs32_aicx

Parametrised advanced interrupt controller for the HS32 core. It is the successor to the fixed 24-line controller and adds configurable line count and NMI count, per-vector edge/level mode, latched pending bits with write-1-to-clear, and a request/acknowledge/end-of-interrupt handshake with the core. It sits on the MMIO bus beside the other peripherals and drives the core's interrupt inputs.

## Interface
- `NIRQ`, 24: number of interrupt lines, 2..32.
- `NNMI`, 2: lines 0..NNMI-1 are non-maskable, 0..NIRQ.
- `AW`, 10: bus address width, at least 8.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `stb` in 1: bus strobe.
- `ack` out 1: bus acknowledge, registered.
- `addr` in AW: byte address; word index = addr[7:2].
- `dtw` in 32: write data.
- `dtr` out 32: read data, registered.
- `rw` in 1: 1 = write.
- `irq_in` in NIRQ: raw interrupt lines.
- `intrq` out 1: interrupt request to core.
- `vec` out 5: requested vector.
- `handler` out 32: ISR address, entry & ~32'hF.
- `nmi` out 1: intrq && vec < NNMI.
- `irq_ack` in 1: core accepts the current request.
- `irq_eoi` in 1: core finished the ISR.

## Operation
- Register map by word index:
  - 0 = PEND. Read gives pending bits; write 1 clears edge latches.
  - 1..NIRQ = table entry for vector idx-1: [31:4] handler, bit1 edge mode, bit0 enable. R/W.
  - 63 = STATUS, read-only: bit31 = ACTIVE, bits[4:0] = in-service vector.
  - Other indices read 0; writes to them are ignored.
- Pending per vector:
  - Level mode: pending = irq_in[i].
  - Edge mode: latch sets on irq_in[i] & ~prev[i], where prev is irq_in registered.
  - Edge latch clears on a PEND W1C write, or on irq_ack while that vector is latched.
  - If a set and a clear hit the same cycle, set wins.
- Eligible = pending & (enable | i<NNMI). NMI vectors ignore the enable bit.
- Priority: lowest eligible index wins.
- FSM:
  - IDLE: if any vector is eligible, latch vec/handler and go to REQ.
  - REQ: intrq=1 and vec/handler hold stable, with no re-arbitration. On irq_ack go to ACTIVE. If the latched vector is no longer eligible before ack (level withdrawn, or W1C), go to IDLE with no ack.
  - ACTIVE: intrq=0, no new requests. On irq_eoi go to IDLE. irq_eoi is ignored in every other state.
- A table write during REQ/ACTIVE does not change the latched handler output.

## Timing
- Reset values:
  - Table entries, edge latches and prev are 0; FSM is IDLE.
  - intrq, nmi, ack and vec are 0; dtr and handler are 0.
- Bus:
  - A write or read commits on the edge where stb && !ack.
  - ack is high for exactly the next cycle, with dtr valid in that cycle.
  - The master drops stb after ack. If stb is held, a new access starts every 2 cycles.
- Latency:
  - Level line high at cycle n gives intrq=1 at cycle n+1.
  - Edge line rising at cycle n gives the latch set at n+1 and intrq at n+2.
- intrq drops the cycle after the irq_ack edge. The next request is possible one cycle after the irq_eoi edge.
- reset mid-operation returns to IDLE immediately and drops intrq the next cycle.

## Structure
- Package `hs32_aic_pkg` holds:
  - the FSM state enum (IDLE/REQ/ACTIVE);
  - register index constants (PEND=0, STATUS=63);
  - entry bit positions (EN=0, EDGE=1, HANDLER_LSB=4).
- Sub-module `hs32_aic_prio`: parametrised lowest-index priority encoder, NIRQ to 5-bit index plus a valid flag.

## Test plan
- Write entry 5 = 32'h0000_1231 (enabled, level), raise irq_in[5] -> intrq at +1 cycle, vec=5, handler=32'h0000_1230, nmi=0.
- Edge vector 7 enabled, pulse irq_in[7] for 1 cycle, never ack -> PEND bit7=1, intrq held. W1C 32'h80 -> intrq=0 the cycle after ack.
- Raise irq_in[1] with entry 2 = 0 (disabled) -> request with vec=1 and nmi=1. irq_in[3] disabled alone -> no intrq.
- irq_in[9] and irq_in[4] both enabled -> vec=4. irq_ack -> ACTIVE, STATUS=32'h8000_0004. irq_eoi -> vec=9 request next.
- Level vector 6 in REQ, drop irq_in[6] before ack -> intrq=0 next cycle, FSM in IDLE.
- Assert reset during ACTIVE -> all table reads return 0, intrq=0, STATUS=0.

Source files
------------

// File: rtl/hs32_aic_pkg.sv
// Shared types and constants for the hs32_aicx interrupt controller.
package hs32_aic_pkg;

  // Request handshake state with the core
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } aic_state_e;

  // Word indices (addr[7:2]) of the fixed registers
  localparam logic [5:0] IDX_PEND   = 6'd0;
  localparam logic [5:0] IDX_STATUS = 6'd63;

  // Bit positions inside a vector table entry
  localparam int ENT_EN          = 0;
  localparam int ENT_EDGE        = 1;
  localparam int ENT_HANDLER_LSB = 4;

  // ISR address carried by a table entry (low bits forced to zero)
  function automatic logic [31:0] handler_of(input logic [31:0] entry);
    handler_of = (entry >> ENT_HANDLER_LSB) << ENT_HANDLER_LSB;
  endfunction

endpackage

// File: rtl/hs32_aic_prio.sv
// Lowest-index-wins priority encoder over the eligible interrupt vectors.
module hs32_aic_prio #(
  parameter int NIRQ = 24
) (
  input  logic [NIRQ-1:0] req,
  output logic [4:0]      idx,
  output logic            valid
);

  // Scan from the top down so the lowest set bit is the last one assigned
  always_comb begin
    idx   = 5'd0;
    valid = 1'b0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      idx   = req[i] ? 5'(i) : idx;
      valid = valid | req[i];
    end
  end

endmodule

// File: rtl/hs32_aicx.sv
// hs32_aicx: parametrised interrupt controller with MMIO vector table,
// edge/level pending logic and a req/ack/eoi handshake towards the core.
module hs32_aicx
  import hs32_aic_pkg::*;
#(
  parameter int NIRQ = 24,
  parameter int NNMI = 2,
  parameter int AW   = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stb,
  output logic            ack,
  input  logic [AW-1:0]   addr,
  input  logic [31:0]     dtw,
  output logic [31:0]     dtr,
  input  logic            rw,
  input  logic [NIRQ-1:0] irq_in,
  output logic            intrq,
  output logic [4:0]      vec,
  output logic [31:0]     handler,
  output logic            nmi,
  input  logic            irq_ack,
  input  logic            irq_eoi
);

  aic_state_e      state_r;
  logic [31:0]     table_r [NIRQ];
  logic [NIRQ-1:0] prev_r, latch_r;
  logic            ack_r, intrq_r, nmi_r;
  logic [31:0]     dtr_r, handler_r;
  logic [4:0]      vec_r;

  logic [NIRQ-1:0] en_s, edge_s, nmimask_s, vec_oh_s;
  logic [NIRQ-1:0] pending_s, eligible_s, set_s, clr_s;
  logic [5:0]      idx_s;
  logic            acc_s, wr_s, pend_wr_s, cur_elig_s;
  logic [4:0]      sel_vec_s;
  logic            sel_valid_s;
  logic [31:0]     sel_entry_s, rd_data_s;
  logic            unused_s;

  assign idx_s     = addr[7:2];
  assign acc_s     = stb && !ack_r;
  assign wr_s      = acc_s && rw;
  assign pend_wr_s = wr_s && (idx_s == IDX_PEND);
  assign unused_s  = ^{addr >> 4'd8, addr[1:0], dtw[3:2]};

  // Per-vector decode of mode/enable bits, pending, eligibility and latch set/clear
  always_comb begin
    en_s      = {NIRQ{1'b0}};
    edge_s    = {NIRQ{1'b0}};
    nmimask_s = {NIRQ{1'b0}};
    vec_oh_s  = {NIRQ{1'b0}};
    for (int i = 0; i < NIRQ; i++) begin
      en_s[i]      = table_r[i][ENT_EN];
      edge_s[i]    = table_r[i][ENT_EDGE];
      nmimask_s[i] = (i < NNMI);
      vec_oh_s[i]  = (vec_r == 5'(i));
    end
    pending_s  = (edge_s & latch_r) | (~edge_s & irq_in);
    eligible_s = pending_s & (en_s | nmimask_s);
    cur_elig_s = |(eligible_s & vec_oh_s);
    set_s      = edge_s & irq_in & ~prev_r;
    clr_s      = (pend_wr_s ? dtw[NIRQ-1:0] : {NIRQ{1'b0}}) |
                 (((state_r == ST_REQ) && irq_ack) ? vec_oh_s : {NIRQ{1'b0}});
  end

  hs32_aic_prio #(.NIRQ(NIRQ)) u_prio (
    .req   (eligible_s),
    .idx   (sel_vec_s),
    .valid (sel_valid_s)
  );

  // Table entry of the winning vector and bus read mux
  always_comb begin
    sel_entry_s = 32'd0;
    rd_data_s   = 32'd0;
    for (int i = 0; i < NIRQ; i++) begin
      sel_entry_s = (sel_vec_s == 5'(i)) ? table_r[i] : sel_entry_s;
    end
    case (idx_s)
      IDX_PEND:   rd_data_s = 32'(pending_s);
      IDX_STATUS: rd_data_s = (state_r == ST_ACTIVE) ? {1'b1, 26'd0, vec_r} : 32'd0;
      default: begin
        for (int i = 0; i < NIRQ; i++) begin
          rd_data_s = (idx_s == 6'(i + 1)) ? table_r[i] : rd_data_s;
        end
      end
    endcase
  end

  // Bus slave: one-cycle ack, registered read data, vector table writes
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r <= 1'b0;
      dtr_r <= 32'd0;
      for (int i = 0; i < NIRQ; i++) table_r[i] <= 32'd0;
    end else begin
      ack_r <= acc_s;
      if (acc_s) dtr_r <= rw ? 32'd0 : rd_data_s;
      for (int i = 0; i < NIRQ; i++) begin
        if (wr_s && (idx_s == 6'(i + 1))) table_r[i] <= {dtw[31:4], 2'b00, dtw[1:0]};
      end
    end
  end

  // Edge detection; a set in the same cycle as a clear takes precedence
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r  <= {NIRQ{1'b0}};
      latch_r <= {NIRQ{1'b0}};
    end else begin
      prev_r  <= irq_in;
      latch_r <= (latch_r & ~clr_s) | set_s;
    end
  end

  // Request handshake FSM; vec/handler stay frozen from arbitration until IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      intrq_r   <= 1'b0;
      nmi_r     <= 1'b0;
      vec_r     <= 5'd0;
      handler_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_valid_s) begin
            state_r   <= ST_REQ;
            intrq_r   <= 1'b1;
            nmi_r     <= (int'(sel_vec_s) < NNMI);
            vec_r     <= sel_vec_s;
            handler_r <= handler_of(sel_entry_s);
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state_r <= ST_ACTIVE;
            intrq_r <= 1'b0;
            nmi_r   <= 1'b0;
          end else if (!cur_elig_s) begin
            state_r <= ST_IDLE;
            intrq_r <= 1'b0;
            nmi_r   <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (irq_eoi) state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          intrq_r <= 1'b0;
          nmi_r   <= 1'b0;
        end
      endcase
    end
  end

  assign ack     = ack_r;
  assign dtr     = dtr_r;
  assign intrq   = intrq_r;
  assign nmi     = nmi_r;
  assign vec     = vec_r;
  assign handler = handler_r;

endmodule

// File: tb/tb_hs32_aicx.sv
// Directed self-checking bench for hs32_aicx (NIRQ=24, NNMI=2, AW=10).
module tb_hs32_aicx;

  localparam int NIRQ = 24;
  localparam int AW   = 10;

  logic            clk = 1'b0;
  logic            reset, stb, rw, irq_ack, irq_eoi;
  logic [AW-1:0]   addr;
  logic [31:0]     dtw;
  logic [NIRQ-1:0] irq_in;
  logic            ack, intrq, nmi;
  logic [31:0]     dtr, handler;
  logic [4:0]      vec;

  typedef struct {
    logic [4:0]  vec;
    logic [31:0] handler;
    logic        nmi;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  string       tag_q[$];
  int          errors = 0;
  int          checks = 0;

  hs32_aicx #(.NIRQ(NIRQ), .NNMI(2), .AW(AW)) dut (
    .clk(clk), .reset(reset), .stb(stb), .ack(ack), .addr(addr), .dtw(dtw),
    .dtr(dtr), .rw(rw), .irq_in(irq_in), .intrq(intrq), .vec(vec),
    .handler(handler), .nmi(nmi), .irq_ack(irq_ack), .irq_eoi(irq_eoi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    logic got = 1'b0;
    addr = {2'b00, a}; dtw = d; rw = 1'b1; stb = 1'b1;
    for (int n = 0; n < 4 && !got; n++) begin
      @(negedge clk);
      got = ack;
    end
    chk("bus_wr_ack", 32'(got), 32'd1);
    stb = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    logic got = 1'b0;
    rd_q.push_back(exp);
    tag_q.push_back(tag);
    addr = {2'b00, a}; rw = 1'b0; stb = 1'b1;
    for (int n = 0; n < 4 && !got; n++) begin
      @(negedge clk);
      got = ack;
    end
    if (got) chk(tag_q.pop_front(), dtr, rd_q.pop_front());
    else begin
      chk({tag_q.pop_front(), "_ack"}, 32'd0, 32'd1);
      void'(rd_q.pop_front());
    end
    stb = 1'b0;
  endtask

  // Waits for intrq; optionally drops irq_in[pulse] after the first cycle
  task automatic expect_req(input int lat, input int pulse, input string tag);
    req_t r = req_q.pop_front();
    int   n = 0;
    logic got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (pulse >= 0 && n == 1) irq_in[pulse] = 1'b0;
      got = intrq;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_vec"}, 32'(vec), 32'(r.vec));
    chk({tag, "_handler"}, handler, r.handler);
    chk({tag, "_nmi"}, 32'(nmi), 32'(r.nmi));
  endtask

  task automatic pulse_ack(input string tag);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk({tag, "_drop"}, 32'(intrq), 32'd0);
  endtask

  task automatic pulse_eoi();
    irq_eoi = 1'b1;
    @(negedge clk);
    irq_eoi = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stb = 1'b0; rw = 1'b0; addr = {AW{1'b0}}; dtw = 32'd0;
    irq_in = {NIRQ{1'b0}}; irq_ack = 1'b0; irq_eoi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_intrq", 32'(intrq), 32'd0);
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_handler", handler, 32'd0);
    chk("rst_nmi", 32'(nmi), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dtr", dtr, 32'd0);
    reset = 1'b0;
    bus_rd(8'h18, 32'd0, "rst_entry5");
    bus_rd(8'hFC, 32'd0, "rst_status");

    // Level vector 5
    bus_wr(8'h18, 32'h0000_1231);
    bus_rd(8'h18, 32'h0000_1231, "entry5_rb");
    req_q.push_back('{5'd5, 32'h0000_1230, 1'b0});
    irq_in[5] = 1'b1;
    expect_req(1, -1, "lvl5");
    pulse_ack("lvl5");
    bus_rd(8'hFC, 32'h8000_0005, "status5");
    irq_in[5] = 1'b0;
    pulse_eoi();
    repeat (2) @(negedge clk);
    chk("idle_after_eoi", 32'(intrq), 32'd0);
    bus_rd(8'hFC, 32'd0, "status_idle1");

    // Edge vector 7, one-cycle pulse, cleared by W1C
    bus_wr(8'h20, 32'h0000_2003);
    req_q.push_back('{5'd7, 32'h0000_2000, 1'b0});
    irq_in[7] = 1'b1;
    expect_req(2, 7, "edge7");
    bus_rd(8'h00, 32'h0000_0080, "pend7");
    repeat (3) @(negedge clk);
    chk("edge7_hold", 32'(intrq), 32'd1);
    bus_wr(8'h00, 32'h0000_0080);
    @(negedge clk);
    chk("w1c7_drop", 32'(intrq), 32'd0);
    bus_rd(8'h00, 32'd0, "pend_clr");

    // NMI vector 1 with disabled entry; disabled vector 3 stays quiet
    req_q.push_back('{5'd1, 32'd0, 1'b1});
    irq_in[1] = 1'b1;
    expect_req(1, -1, "nmi1");
    pulse_ack("nmi1");
    irq_in[1] = 1'b0;
    pulse_eoi();
    irq_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    chk("dis3_quiet", 32'(intrq), 32'd0);
    irq_in[3] = 1'b0;

    // Priority 4 over 9, then 9 after eoi; table write must not disturb handler
    bus_wr(8'h14, 32'h0000_4001);
    bus_wr(8'h28, 32'h0000_9001);
    req_q.push_back('{5'd4, 32'h0000_4000, 1'b0});
    irq_in[4] = 1'b1;
    irq_in[9] = 1'b1;
    expect_req(1, -1, "prio4");
    pulse_ack("prio4");
    bus_rd(8'hFC, 32'h8000_0004, "status4");
    irq_in[4] = 1'b0;
    req_q.push_back('{5'd9, 32'h0000_9000, 1'b0});
    pulse_eoi();
    expect_req(1, -1, "next9");
    bus_wr(8'h28, 32'h0000_A001);
    chk("hold_handler9", handler, 32'h0000_9000);
    chk("hold_vec9", 32'(vec), 32'd9);
    bus_rd(8'h28, 32'h0000_A001, "entry9_rb");
    pulse_ack("next9");
    irq_in[9] = 1'b0;
    pulse_eoi();

    // Level vector 6 withdrawn before ack
    bus_wr(8'h1C, 32'h0000_6001);
    req_q.push_back('{5'd6, 32'h0000_6000, 1'b0});
    irq_in[6] = 1'b1;
    expect_req(1, -1, "lvl6");
    irq_in[6] = 1'b0;
    @(negedge clk);
    chk("withdraw6", 32'(intrq), 32'd0);
    bus_rd(8'hFC, 32'd0, "status_idle2");

    // Reset while ACTIVE
    req_q.push_back('{5'd5, 32'h0000_1230, 1'b0});
    irq_in[5] = 1'b1;
    expect_req(1, -1, "lvl5b");
    pulse_ack("lvl5b");
    bus_rd(8'hFC, 32'h8000_0005, "status5b");
    irq_in[5] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_intrq", 32'(intrq), 32'd0);
    chk("mid_rst_handler", handler, 32'd0);
    bus_rd(8'h18, 32'd0, "mid_rst_entry5");
    bus_rd(8'h20, 32'd0, "mid_rst_entry7");
    bus_rd(8'h28, 32'd0, "mid_rst_entry9");
    bus_rd(8'hFC, 32'd0, "mid_rst_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
